// File: rtl/uart_in_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_in_responder
// Brief    : Host-filled character FIFO answering SimTop UART input requests,
//            returning EMPTY_CH when nothing is buffered.
// Revision : 1.0
// ============================================================================
module uart_in_responder #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  EMPTY_CH = 8'hFF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [7:0]                 push_ch,
    output logic                       push_ready,
    input  logic                       io_uart_in_valid,
    output logic [7:0]                 io_uart_in_ch,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [31:0]                served_cnt,
    output logic [31:0]                empty_cnt
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam int                c_LW   = c_AW + 1;
    localparam logic [c_LW-1:0]   c_FULL = c_LW'(DEPTH);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_overflow;
    logic [31:0]     r_served_cnt;
    logic [31:0]     r_empty_cnt;

    logic w_full;
    logic w_fifo_empty;
    logic w_push;
    logic w_pop;
    logic w_req_empty;

    assign w_full       = (r_level == c_FULL);
    assign w_fifo_empty = (r_level == '0);
    // A push into a full FIFO is dropped even when a pop frees a slot this edge.
    assign w_push       = push_valid && !w_full;
    assign w_pop        = io_uart_in_valid && !w_fifo_empty;
    assign w_req_empty  = io_uart_in_valid && w_fifo_empty;

    assign push_ready    = !w_full;
    assign io_uart_in_ch = w_fifo_empty ? EMPTY_CH : r_mem[r_rd_ptr];
    assign level         = r_level;
    assign overflow      = r_overflow;
    assign served_cnt    = r_served_cnt;
    assign empty_cnt     = r_empty_cnt;

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= push_ch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_served_cnt <= '0;
            r_empty_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr     <= r_rd_ptr + c_AW'(1);
                r_served_cnt <= r_served_cnt + 32'd1;
            end
            if (w_req_empty) begin
                r_empty_cnt <= r_empty_cnt + 32'd1;
            end
            if (push_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_in_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_in_responder
// Brief    : Self-checking bench; a queue-based model predicts every response.
// Revision : 1.0
// ============================================================================
module tb_uart_in_responder;

    localparam int         DEPTH    = 16;
    localparam logic [7:0] EMPTY_CH = 8'hFF;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        push_valid = 1'b0;
    logic [7:0]  push_ch = 8'h00;
    logic        push_ready;
    logic        io_uart_in_valid = 1'b0;
    logic [7:0]  io_uart_in_ch;
    logic [4:0]  level;
    logic        overflow;
    logic [31:0] served_cnt;
    logic [31:0] empty_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  q[$];
    int unsigned m_served = 0;
    int unsigned m_empty  = 0;
    bit          m_ov     = 1'b0;

    uart_in_responder #(.DEPTH(DEPTH), .EMPTY_CH(EMPTY_CH)) dut (
        .clock            (clock),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_ch          (push_ch),
        .push_ready       (push_ready),
        .io_uart_in_valid (io_uart_in_valid),
        .io_uart_in_ch    (io_uart_in_ch),
        .level            (level),
        .overflow         (overflow),
        .served_cnt       (served_cnt),
        .empty_cnt        (empty_cnt)
    );

    always #5 clock = ~clock;

    // One clock of stimulus; got is sampled before the edge, exp comes from the queue.
    task automatic drive_cycle(input bit pv, input logic [7:0] pc, input bit rv,
                               output logic [7:0] got, output logic [7:0] exp);
        bit was_full;
        bit was_empty;
        push_valid       = pv;
        push_ch          = pc;
        io_uart_in_valid = rv;
        #1;
        got = io_uart_in_ch;
        exp = (q.size() != 0) ? q[0] : EMPTY_CH;
        @(posedge clock);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (pv && was_full) m_ov = 1'b1;
        if (rv) begin
            if (was_empty) m_empty++;
            else begin
                void'(q.pop_front());
                m_served++;
            end
        end
        if (pv && !was_full) q.push_back(pc);
        @(negedge clock);
        push_valid       = 1'b0;
        io_uart_in_valid = 1'b0;
    endtask

    // Leaves reset asserted at a falling edge so callers can observe reset-time outputs.
    task automatic apply_reset(input int cycles);
        reset            = 1'b1;
        push_valid       = 1'b1;
        push_ch          = 8'h55;
        io_uart_in_valid = 1'b1;
        repeat (cycles) @(posedge clock);
        @(negedge clock);
        q.delete();
        m_served = 0;
        m_empty  = 0;
        m_ov     = 1'b0;
    endtask

    task automatic release_reset();
        reset            = 1'b0;
        push_valid       = 1'b0;
        io_uart_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_checks++;
        if (push_ready !== 1'b1) begin n_errors++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
        n_checks++;
        if (io_uart_in_ch !== EMPTY_CH) begin n_errors++; $display("FAIL reset_ch got=%h exp=%h", io_uart_in_ch, EMPTY_CH); end
        n_checks++;
        if (level !== 5'd0 || overflow !== 1'b0) begin n_errors++; $display("FAIL reset_level_ov got=%0d/%b exp=0/0", level, overflow); end
        n_checks++;
        if (served_cnt !== 32'd0 || empty_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", served_cnt, empty_cnt); end
        release_reset();
    endtask

    task automatic test_empty_requests();
        logic [7:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, got, exp);
            n_checks++;
            if (got !== 8'hFF) begin n_errors++; $display("FAIL empty_resp%0d got=%h exp=ff", i, got); end
        end
        n_checks++;
        if (empty_cnt !== 32'd3 || served_cnt !== 32'd0 || level !== 5'd0) begin
            n_errors++; $display("FAIL empty_counts got=%0d/%0d/%0d exp=3/0/0", empty_cnt, served_cnt, level);
        end
    endtask

    task automatic test_hi();
        logic [7:0] got, exp;
        logic [7:0] msg [3];
        msg[0] = 8'h68; msg[1] = 8'h69; msg[2] = 8'h0A;
        apply_reset(1); release_reset();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, msg[i], 1'b0, got, exp);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, got, exp);
            n_checks++;
            if (got !== msg[i]) begin n_errors++; $display("FAIL hi_resp%0d got=%h exp=%h", i, got, msg[i]); end
        end
        n_checks++;
        if (served_cnt !== 32'd3 || level !== 5'd0) begin n_errors++; $display("FAIL hi_counts got=%0d/%0d exp=3/0", served_cnt, level); end
    endtask

    task automatic test_overflow();
        logic [7:0] got, exp;
        apply_reset(1); release_reset();
        for (int i = 0; i <= 16; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0, got, exp);
            if (i == 15) begin
                n_checks++;
                if (push_ready !== 1'b0 || overflow !== 1'b0) begin n_errors++; $display("FAIL full_ready got=%b/%b exp=0/0", push_ready, overflow); end
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || level !== 5'd16 || push_ready !== 1'b0) begin
            n_errors++; $display("FAIL overflow_state got=%b/%0d/%b exp=1/16/0", overflow, level, push_ready);
        end
        for (int i = 0; i < 17; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, got, exp);
            n_checks++;
            if (got !== ((i < 16) ? 8'(i) : EMPTY_CH)) begin n_errors++; $display("FAIL drain%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] got, exp;
        apply_reset(1); release_reset();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'(8'h20 + i), 1'b0, got, exp);
        drive_cycle(1'b1, 8'hAB, 1'b1, got, exp);
        n_checks++;
        if (got !== 8'h20) begin n_errors++; $display("FAIL fullpp_resp got=%h exp=20", got); end
        n_checks++;
        if (overflow !== 1'b1 || level !== 5'd15) begin n_errors++; $display("FAIL fullpp_state got=%b/%0d exp=1/15", overflow, level); end
        for (int i = 0; i < 15; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b1, got, exp);
            n_checks++;
            if (got !== exp) begin n_errors++; $display("FAIL fullpp_drain%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp;
        apply_reset(1); release_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom), 1'b0, got, exp);
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, 8'($urandom), 1'b1, got, exp);
            n_checks++;
            if (got !== exp || level !== 5'd5) begin n_errors++; $display("FAIL b2b%0d got=%h/%0d exp=%h/5", i, got, level, exp); end
        end
        n_checks++;
        if (served_cnt !== 32'd40) begin n_errors++; $display("FAIL b2b_served got=%0d exp=40", served_cnt); end
    endtask

    task automatic test_simultaneous_empty();
        logic [7:0] got, exp;
        apply_reset(1); release_reset();
        drive_cycle(1'b1, 8'h41, 1'b1, got, exp);
        n_checks++;
        if (got !== EMPTY_CH || empty_cnt !== 32'd1 || level !== 5'd1) begin
            n_errors++; $display("FAIL simul_empty got=%h/%0d/%0d exp=ff/1/1", got, empty_cnt, level);
        end
        drive_cycle(1'b1, EMPTY_CH, 1'b1, got, exp);
        drive_cycle(1'b0, 8'h00, 1'b1, got, exp);
        n_checks++;
        if (got !== EMPTY_CH || served_cnt !== 32'd2 || empty_cnt !== 32'd1 || level !== 5'd0) begin
            n_errors++; $display("FAIL data_ff got=%h/%0d/%0d/%0d exp=ff/2/1/0", got, served_cnt, empty_cnt, level);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        apply_reset(1); release_reset();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45), got, exp);
            n_checks++;
            if (got !== exp || level !== 5'(q.size()) || push_ready !== (q.size() != DEPTH)) begin
                n_errors++; $display("FAIL rand%0d ch=%h/%h level=%0d/%0d", i, got, exp, level, q.size());
            end
        end
        n_checks++;
        if (overflow !== m_ov || served_cnt !== m_served || empty_cnt !== m_empty) begin
            n_errors++; $display("FAIL rand_stats got=%b/%0d/%0d exp=%b/%0d/%0d", overflow, served_cnt, empty_cnt, m_ov, m_served, m_empty);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got, exp;
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h30 + i), 1'b0, got, exp);
        n_checks++;
        if (level !== 5'(q.size())) begin n_errors++; $display("FAIL mid_pre_level got=%0d exp=%0d", level, q.size()); end
        apply_reset(1); release_reset();
        n_checks++;
        if (level !== 5'd0 || overflow !== 1'b0 || served_cnt !== 32'd0 || empty_cnt !== 32'd0) begin
            n_errors++; $display("FAIL mid_reset_state got=%0d/%b/%0d/%0d exp=0/0/0/0", level, overflow, served_cnt, empty_cnt);
        end
        drive_cycle(1'b0, 8'h00, 1'b1, got, exp);
        n_checks++;
        if (got !== 8'hFF) begin n_errors++; $display("FAIL mid_reset_resp got=%h exp=ff", got); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_empty_requests();
        test_hi();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_simultaneous_empty();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_in_responder.md
UART_IN_RESPONDER -- requirements
Module: uart_in_responder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two and at least 2.
REQ-002 Parameter EMPTY_CH, default 8'hFF, character returned when no data is buffered.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
REQ-004 The remaining ports SHALL be:
- push_valid  in  1  host (bench/DPI) offers one character this cycle
- push_ch  in  8  character offered by the host
- push_ready  out  1  FIFO can accept a character this cycle
- io_uart_in_valid  in  1  SimTop requests one input character this cycle
- io_uart_in_ch  out  8  character answered to SimTop
- level  out  log2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a push was dropped
- served_cnt  out  32  requests answered with real data
- empty_cnt  out  32  requests answered with EMPTY_CH

Function
REQ-005 Storage SHALL be a circular FIFO of DEPTH 8-bit entries with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-006 push_ready SHALL equal (level != DEPTH), derived from registered state only.
REQ-007 A push SHALL occur on a rising edge where push_valid && push_ready; push_ch is written at the write pointer, which then advances.
REQ-008 push_valid while level == DEPTH SHALL discard the character, leave the FIFO unchanged, and set overflow; this applies even if a pop occurs in the same cycle.
REQ-009 io_uart_in_ch SHALL be combinational: the FIFO head when level != 0, else EMPTY_CH; it SHALL NOT depend on push_valid or push_ch (no bypass).
REQ-010 A pop SHALL occur on a rising edge where io_uart_in_valid && level != 0; the read pointer then advances, and served_cnt increments by 1.
REQ-011 io_uart_in_valid while level == 0 SHALL leave the FIFO unchanged and increment empty_cnt by 1.
REQ-012 When a push and a pop occur on the same edge, level SHALL be unchanged and both pointers SHALL advance.
REQ-013 When push and request coincide with level == 0, the response SHALL be EMPTY_CH, empty_cnt SHALL increment, and the character SHALL be stored, giving level 1.
REQ-014 Updates per edge: level += push − pop; level SHALL never exceed DEPTH or go below 0.
REQ-015 served_cnt and empty_cnt SHALL wrap modulo 2^32 without saturation.
REQ-016 Request handling SHALL take one cycle per request; back-to-back requests on consecutive cycles SHALL return consecutive FIFO entries in push order.
REQ-017 A character whose value equals EMPTY_CH SHALL be stored and returned like any other and counted in served_cnt.

Reset
REQ-018 While reset is high at a rising edge, the block SHALL clear both pointers and level, overflow, served_cnt, and empty_cnt to 0.
REQ-019 During reset, push_ready SHALL be 1 and io_uart_in_ch SHALL be EMPTY_CH.
REQ-020 During reset, pushes and requests SHALL be ignored and no counter SHALL change.
REQ-021 Reset asserted mid-operation SHALL discard all buffered characters; the first request after reset SHALL return EMPTY_CH.

Verification
REQ-022 Reset, then request on 3 cycles with no pushes -> io_uart_in_ch = 8'hFF each cycle, empty_cnt = 3, served_cnt = 0, level = 0.
REQ-023 Push 'h','i','\n' (8'h68, 8'h69, 8'h0A), then 3 back-to-back requests -> responses 68, 69, 0A; served_cnt = 3; level ends at 0.
REQ-024 Push 17 characters 8'h00..8'h10 with DEPTH = 16 and no requests -> push_ready = 0 after the 16th push, overflow = 1, level = 16; draining returns 00..0F only.
REQ-025 Full FIFO with push_valid and request on the same cycle -> head returned, pushed character dropped, overflow = 1, level = 15.
REQ-026 Level 5 with simultaneous push and request for 40 cycles -> level stays 5, responses remain in push order across pointer wrap, served_cnt = 40.
REQ-027 Level 4, then reset pulsed for 1 cycle -> level = 0, overflow = 0, counters = 0; the next request returns 8'hFF.
